// File: rtl/vm_pkg.sv
// Shared types and coin tables for the multi-product vending machine.
// Coin bit order is fixed: 1, 2, 5, 10, 20, 50 units.
package vm_pkg;

  localparam int N_COINS = 6;

  localparam int C1  = 0;
  localparam int C2  = 1;
  localparam int C5  = 2;
  localparam int C10 = 3;
  localparam int C20 = 4;
  localparam int C50 = 5;

  localparam int COIN_VAL [N_COINS] = '{1, 2, 5, 10, 20, 50};

  typedef enum logic [1:0] {
    IDLE,
    VEND,
    CHANGE
  } state_e;

  // Anything that is not exactly one coin is worth nothing.
  function automatic int coin_value(input logic [N_COINS-1:0] oh);
    int v;
    v = 0;
    if ($onehot(oh)) begin
      for (int i = 0; i < N_COINS; i++) begin
        if (oh[i]) v = COIN_VAL[i];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/vending_machine_multi_change.sv
// Greedy change dispenser: one coin per enabled cycle.
// done_o flags the cycle whose coin empties the remainder.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [CREDIT_W-1:0] amount_i,
  input  logic                en_i,
  output logic [N_COINS-1:0]  coin_o,
  output logic                done_o
);

  logic [CREDIT_W-1:0] rem_q;
  logic [CREDIT_W-1:0] rem_d;
  logic [CREDIT_W-1:0] val;
  logic [N_COINS-1:0]  pick;

  always_comb begin
    logic found;
    found = 1'b0;
    pick  = '0;
    for (int i = N_COINS - 1; i >= 0; i--) begin
      if (!found && rem_q >= CREDIT_W'(COIN_VAL[i])) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign val    = CREDIT_W'(coin_value(pick));
  assign coin_o = en_i ? pick : '0;
  assign done_o = en_i && (rem_q == val);

  always_comb begin
    rem_d = rem_q;
    if (load_i)    rem_d = amount_i;
    else if (en_i) rem_d = rem_q - val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending FSM with edge-detected coins,
// overflow rejection, cancel/refund and greedy change.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = 8,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES =
    {8'd40, 8'd25, 8'd15, 8'd50},
  parameter int MAX_CREDIT = 200,
  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_COINS-1:0]  coin_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                cancel,
  output logic                drink,
  output logic [SEL_W-1:0]    prod,
  output logic [N_COINS-1:0]  coin_out,
  output logic [N_COINS-1:0]  coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [SEL_W-1:0]     prod_q, prod_d;
  logic [N_COINS-1:0]   rej_q, rej_d;
  logic [N_COINS-1:0]   coin_q;
  logic                 buy_q, cancel_q;

  logic [N_COINS-1:0]   coin_edge;
  logic                 buy_edge, cancel_edge;
  logic [CREDIT_W-1:0]  cval;
  logic [CREDIT_W:0]    sum;
  logic                 sel_ok;
  logic [CREDIT_W-1:0]  price_sel, price_prod, amt;
  logic                 load;
  logic [CREDIT_W-1:0]  load_amt;
  logic                 disp_done;
  logic [CREDIT_W-1:0]  price_tbl [N_PROD];

  // Entry 0 is the leftmost field of the packed table.
  always_comb begin
    for (int i = 0; i < N_PROD; i++) begin
      price_tbl[i] = PRICES[(N_PROD-1-i)*CREDIT_W +: CREDIT_W];
    end
  end

  assign coin_edge   = coin_in & ~coin_q;
  assign buy_edge    = buy & ~buy_q;
  assign cancel_edge = cancel & ~cancel_q;
  assign cval        = CREDIT_W'(coin_value(coin_edge));
  assign sum         = {1'b0, credit_q} + {1'b0, cval};
  assign sel_ok      = int'(sel) < N_PROD;
  assign price_sel   = sel_ok ? price_tbl[sel] : '0;
  assign price_prod  = price_tbl[prod_q];
  assign amt         = credit_q - price_prod;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    prod_d   = prod_q;
    rej_d    = '0;
    load     = 1'b0;
    load_amt = '0;
    unique case (state_q)
      IDLE: begin
        if (cancel_edge && credit_q != '0) begin
          state_d  = CHANGE;
          load     = 1'b1;
          load_amt = credit_q;
          credit_d = '0;
          rej_d    = coin_edge;
        end else if (buy_edge && sel_ok &&
                     credit_q >= price_sel) begin
          state_d = VEND;
          prod_d  = sel;
          rej_d   = coin_edge;
        end else if (coin_edge != '0) begin
          if (cval != '0 &&
              sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = sum[CREDIT_W-1:0];
          end else begin
            rej_d = coin_edge;
          end
        end
      end
      VEND: begin
        load     = 1'b1;
        load_amt = amt;
        credit_d = '0;
        state_d  = (amt != '0) ? CHANGE : IDLE;
        rej_d    = coin_edge;
      end
      CHANGE: begin
        rej_d = coin_edge;
        if (disp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      prod_q   <= '0;
      rej_q    <= '0;
      coin_q   <= '0;
      buy_q    <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      prod_q   <= prod_d;
      rej_q    <= rej_d;
      coin_q   <= coin_in;
      buy_q    <= buy;
      cancel_q <= cancel;
    end
  end

  change_dispenser #(
    .CREDIT_W(CREDIT_W)
  ) u_disp (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .amount_i(load_amt),
    .en_i    (state_q == CHANGE),
    .coin_o  (coin_out),
    .done_o  (disp_done)
  );

  assign drink    = (state_q == VEND);
  assign prod     = drink ? prod_q : '0;
  assign busy     = (state_q != IDLE);
  assign coin_rej = rej_q;
  assign credit   = credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench: stimulus queues expected vend/change/reject
// events, a negedge monitor pops and compares them.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] coin_in;
  logic [1:0] sel;
  logic       buy;
  logic       cancel;
  logic       drink;
  logic [1:0] prod;
  logic [5:0] coin_out;
  logic [5:0] coin_rej;
  logic [7:0] credit;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [1:0] q_vend [$];
  logic [5:0] q_out  [$];
  logic [5:0] q_rej  [$];

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk     (clk),
    .rst     (rst),
    .coin_in (coin_in),
    .sel     (sel),
    .buy     (buy),
    .cancel  (cancel),
    .drink   (drink),
    .prod    (prod),
    .coin_out(coin_out),
    .coin_rej(coin_rej),
    .credit  (credit),
    .busy    (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (drink) begin
        if (q_vend.size() == 0) chk("unexpected_drink", int'(prod), -1);
        else chk("vend_prod", int'(prod), int'(q_vend.pop_front()));
      end
      if (coin_out != 6'b0) begin
        if (q_out.size() == 0) chk("unexpected_coin_out", int'(coin_out), 0);
        else chk("coin_out", int'(coin_out), int'(q_out.pop_front()));
      end
      if (coin_rej != 6'b0) begin
        if (q_rej.size() == 0) chk("unexpected_coin_rej", int'(coin_rej), 0);
        else chk("coin_rej", int'(coin_rej), int'(q_rej.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int b);
    coin_in = 6'b0;
    coin_in[b] = 1'b1;
    tick();
    coin_in = 6'b0;
    tick();
  endtask

  task automatic do_buy(input logic [1:0] s);
    sel = s;
    buy = 1'b1;
    tick();
    buy = 1'b0;
    tick();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    coin_in = 6'b0;
    sel = 2'd0;
    buy = 1'b0;
    cancel = 1'b0;
    tick();
    tick();
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drink", int'(drink), 0);
    chk("rst_coin_out", int'(coin_out), 0);
    chk("rst_coin_rej", int'(coin_rej), 0);
    rst = 1'b0;
    tick();

    // 1: held 20 counts once, second pulse gives 40, buy product 0
    coin_in = 6'b010000;
    tick();
    tick();
    tick();
    chk("held_20", int'(credit), 20);
    coin_in = 6'b0;
    tick();
    coin(4);
    chk("credit_40", int'(credit), 40);
    q_vend.push_back(2'd0);
    do_buy(2'd0);
    chk("t1_credit0", int'(credit), 0);
    chk("t1_not_busy", int'(busy), 0);

    // 2: 50 in, buy product 2 (15) -> change 20,10,5
    coin(5);
    chk("credit_50", int'(credit), 50);
    q_vend.push_back(2'd2);
    q_out.push_back(6'b010000);
    q_out.push_back(6'b001000);
    q_out.push_back(6'b000100);
    do_buy(2'd2);
    wait_idle();
    chk("t2_credit0", int'(credit), 0);

    // 3: 17 in, cancel -> refund 10,5,2
    coin(3);
    coin(2);
    coin(1);
    chk("credit_17", int'(credit), 17);
    q_out.push_back(6'b001000);
    q_out.push_back(6'b000100);
    q_out.push_back(6'b000010);
    do_cancel();
    chk("t3_credit0", int'(credit), 0);
    wait_idle();

    // 4: ceiling at 200
    coin(5);
    coin(5);
    coin(5);
    coin(4);
    coin(4);
    chk("credit_190", int'(credit), 190);
    q_rej.push_back(6'b010000);
    coin(4);
    chk("overflow_kept", int'(credit), 190);
    coin(3);
    chk("credit_200", int'(credit), 200);
    for (int i = 0; i < 4; i++) q_out.push_back(6'b100000);
    do_cancel();
    wait_idle();

    // 5: coin during CHANGE rejected, then simultaneous edges
    coin(4);
    coin(3);
    coin(2);
    coin(1);
    coin(0);
    chk("credit_38", int'(credit), 38);
    q_out.push_back(6'b010000);
    q_out.push_back(6'b001000);
    q_out.push_back(6'b000100);
    q_out.push_back(6'b000010);
    q_out.push_back(6'b000001);
    q_rej.push_back(6'b000100);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    coin_in = 6'b000100;
    tick();
    coin_in = 6'b0;
    wait_idle();
    q_rej.push_back(6'b000011);
    coin_in = 6'b000011;
    tick();
    coin_in = 6'b0;
    tick();
    chk("multi_rej_credit", int'(credit), 0);

    // exact price: no change
    coin(5);
    q_vend.push_back(2'd3);
    do_buy(2'd3);
    chk("exact_credit0", int'(credit), 0);
    chk("exact_idle", int'(busy), 0);

    // 6: reset with 30 of change pending
    coin(5);
    coin(4);
    chk("credit_70", int'(credit), 70);
    q_vend.push_back(2'd0);
    sel = 2'd0;
    buy = 1'b1;
    tick();
    buy = 1'b0;
    tick();
    chk("change_started", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_coin_out", int'(coin_out), 0);
    chk("rst_mid_credit", int'(credit), 0);
    tick();
    rst = 1'b0;
    tick();
    do_buy(2'd0);
    chk("nocredit_busy", int'(busy), 0);
    tick();
    tick();

    chk("q_vend_empty", q_vend.size(), 0);
    chk("q_out_empty", q_out.size(), 0);
    chk("q_rej_empty", q_rej.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
